// File: rtl/jtkcpu_wordbus.sv
// Two-byte big-endian word access sequencer between the KONAMI-1 16-bit datapath and its 8-bit bus.
// Optional bus wait states are enabled by defining JTKCPU_WORDBUS_WAIT_EN.
module jtkcpu_wordbus #(
   parameter int AW = 16
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          cen,
   input  logic          req,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] bus_addr,
   output logic [7:0]    bus_dout,
   input  logic [7:0]    bus_din,
   output logic          bus_cs,
   output logic          bus_we,
   input  logic          bus_rdy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2
   } state_t;

   state_t        state_r, state_nxt_s;

   logic          lat_we_r;
   logic [AW-1:0] lat_addr_r;
   logic [15:0]   lat_wdata_r;
   logic [7:0]    hold_r, hold_nxt_s;

   logic [15:0]   rdata_r, rdata_nxt_s;
   logic          busy_r, busy_nxt_s;
   logic          done_r, done_nxt_s;
   logic [AW-1:0] bus_addr_r, bus_addr_nxt_s;
   logic [7:0]    bus_dout_r, bus_dout_nxt_s;
   logic          bus_cs_r, bus_cs_nxt_s;
   logic          bus_we_r, bus_we_nxt_s;

   logic          rdy_s;
   logic          advance_s;
   logic          accept_s;
   logic [AW-1:0] addr_lo_s;

`ifdef JTKCPU_WORDBUS_WAIT_EN
   assign rdy_s = bus_rdy;
`else
   // Without wait states the ready input has no effect on phase length.
   assign rdy_s = bus_rdy | 1'b1;
`endif

   assign advance_s = cen & rdy_s;
   assign accept_s  = (state_r == ST_IDLE) & cen & req;
   assign addr_lo_s = lat_addr_r + {{(AW-1){1'b0}}, 1'b1};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cen && req) begin
               state_nxt_s = ST_HI;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HI: begin
            if (advance_s) begin
               state_nxt_s = ST_LO;
            end else begin
               state_nxt_s = ST_HI;
            end
         end
         ST_LO: begin
            if (advance_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_LO;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Request operand latches; only written when a new access is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_we_r    <= 1'b0;
         lat_addr_r  <= {AW{1'b0}};
         lat_wdata_r <= 16'h0000;
      end else if (accept_s) begin
         lat_we_r    <= we;
         lat_addr_r  <= addr;
         lat_wdata_r <= wdata;
      end else begin
         lat_we_r    <= lat_we_r;
         lat_addr_r  <= lat_addr_r;
         lat_wdata_r <= lat_wdata_r;
      end
   end

   // Output logic: next values of the registered outputs, driven from the state being entered
   always_comb begin
      rdata_nxt_s    = rdata_r;
      busy_nxt_s     = busy_r;
      done_nxt_s     = 1'b0;
      bus_addr_nxt_s = bus_addr_r;
      bus_dout_nxt_s = bus_dout_r;
      bus_cs_nxt_s   = bus_cs_r;
      bus_we_nxt_s   = bus_we_r;
      hold_nxt_s     = hold_r;
      case (state_r)
         ST_IDLE: begin
            if (cen && req) begin
               busy_nxt_s     = 1'b1;
               bus_cs_nxt_s   = 1'b1;
               bus_we_nxt_s   = we;
               bus_addr_nxt_s = addr;
               bus_dout_nxt_s = we ? wdata[15:8] : 8'h00;
            end else begin
               busy_nxt_s   = 1'b0;
               bus_cs_nxt_s = 1'b0;
               bus_we_nxt_s = 1'b0;
            end
         end
         ST_HI: begin
            if (advance_s) begin
               bus_addr_nxt_s = addr_lo_s;
               bus_dout_nxt_s = lat_we_r ? lat_wdata_r[7:0] : 8'h00;
               hold_nxt_s     = lat_we_r ? hold_r : bus_din;
            end else begin
               hold_nxt_s = hold_r;
            end
         end
         ST_LO: begin
            if (advance_s) begin
               busy_nxt_s   = 1'b0;
               bus_cs_nxt_s = 1'b0;
               bus_we_nxt_s = 1'b0;
               done_nxt_s   = 1'b1;
               // High and low bytes land together so a half-updated word is never visible
               rdata_nxt_s  = lat_we_r ? rdata_r : {hold_r, bus_din};
            end else begin
               rdata_nxt_s = rdata_r;
            end
         end
         default: begin
            busy_nxt_s   = 1'b0;
            bus_cs_nxt_s = 1'b0;
            bus_we_nxt_s = 1'b0;
         end
      endcase
   end

   // Output and high-byte hold registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_r    <= 16'h0000;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         bus_addr_r <= {AW{1'b0}};
         bus_dout_r <= 8'h00;
         bus_cs_r   <= 1'b0;
         bus_we_r   <= 1'b0;
         hold_r     <= 8'h00;
      end else begin
         rdata_r    <= rdata_nxt_s;
         busy_r     <= busy_nxt_s;
         done_r     <= done_nxt_s;
         bus_addr_r <= bus_addr_nxt_s;
         bus_dout_r <= bus_dout_nxt_s;
         bus_cs_r   <= bus_cs_nxt_s;
         bus_we_r   <= bus_we_nxt_s;
         hold_r     <= hold_nxt_s;
      end
   end

   assign rdata    = rdata_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign bus_addr = bus_addr_r;
   assign bus_dout = bus_dout_r;
   assign bus_cs   = bus_cs_r;
   assign bus_we   = bus_we_r;

endmodule
